// File: rtl/param_frame_rx.sv
// Byte-serial receiver for framed a0/a1 parameter packets: synchronises an async strobe,
// checks header, XOR checksum and inter-byte timeout, and launches only when the core is idle.
module param_frame_rx #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         TIMEOUT_CYC = 1024,
    parameter int         SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [7:0]         byte_in,
    input  logic               byte_stb,
    input  logic               core_busy,
    output logic signed [31:0] a0,
    output logic signed [31:0] a1,
    output logic               start_calc,
    output logic               rx_busy,
    output logic               frame_err,
    output logic [3:0]         err_cnt
);
    localparam int               TMO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 2);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, PEND} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_stb_q;
    logic [63:0]            r_shift;
    logic [7:0]             r_xor;
    logic [2:0]             r_idx;
    logic [TMO_W-1:0]       r_tmo;

    logic w_byte;
    logic w_timing;
    logic w_tmo_hit;
    logic w_fail;

    // NOTE: every flop uses non-blocking (<=) so all state updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_stb_q <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], byte_stb};
            r_stb_q <= r_sync[SYNC_STAGES-1];
        end
    end

    // byte_in is stable while the strobe is high, so it is sampled directly on the edge cycle.
    assign w_byte    = ena & r_sync[SYNC_STAGES-1] & ~r_stb_q;
    assign w_timing  = (r_state == PAYLOAD) || (r_state == CHECK);
    assign w_tmo_hit = w_timing && !w_byte && (r_tmo == TMO_LAST);
    assign w_fail    = ena && (w_tmo_hit
                               || (r_state == CHECK && w_byte && byte_in != r_xor)
                               || (r_state == PEND && w_byte));
    assign rx_busy   = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_xor      <= '0;
            r_idx      <= '0;
            r_tmo      <= '0;
            a0         <= '0;
            a1         <= '0;
            start_calc <= 1'b0;
            frame_err  <= 1'b0;
            err_cnt    <= '0;
        end else begin
            start_calc <= 1'b0;
            frame_err  <= w_fail;
            if (w_fail && err_cnt != 4'hF)
                err_cnt <= err_cnt + 4'd1;

            if (!ena) begin
                r_state <= IDLE;
                r_tmo   <= '0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (w_byte && byte_in == HEADER) begin
                            r_state <= PAYLOAD;
                            r_idx   <= '0;
                            r_xor   <= '0;
                            r_shift <= '0;
                            r_tmo   <= '0;
                        end
                    end
                    PAYLOAD: begin
                        if (w_byte) begin
                            r_shift <= {r_shift[55:0], byte_in};
                            r_xor   <= r_xor ^ byte_in;
                            r_idx   <= r_idx + 3'd1;
                            r_tmo   <= '0;
                            if (r_idx == 3'd7)
                                r_state <= CHECK;
                        end else if (w_tmo_hit) begin
                            r_state <= IDLE;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                    end
                    CHECK: begin
                        if (w_byte) begin
                            r_tmo   <= '0;
                            r_state <= (byte_in == r_xor) ? PEND : IDLE;
                        end else if (w_tmo_hit) begin
                            r_state <= IDLE;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                    end
                    PEND: begin
                        // An overrun byte here is flagged via w_fail; the held frame survives.
                        if (!core_busy) begin
                            a0         <= r_shift[63:32];
                            a1         <= r_shift[31:0];
                            start_calc <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_param_frame_rx.sv
// Randomised bench for param_frame_rx: a frame-level model predicts every output each cycle,
// with directed scenarios pinning literal values.
module tb_param_frame_rx;
    localparam logic [7:0] HDR = 8'hA5;
    localparam int         TMO = 1024;
    localparam int         SYN = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 1'b0;
    logic              byte_stb = 1'b0;
    logic              core_busy = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic signed [31:0] a0, a1;
    logic              start_calc, rx_busy, frame_err;
    logic [3:0]        err_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_rise = 0;
    int err_edge = -1;
    int start_seen = 0;
    bit cmp_en = 1'b0;

    // Model state: strobe sample history, collection mode (0 idle, 1 collecting, 2 pending).
    bit          stb_h[SYN+2];
    int          m_mode = 0;
    logic [7:0]  m_fq[$];
    int          m_idle = 0;
    logic [31:0] e_a0 = '0;
    logic [31:0] e_a1 = '0;
    logic        e_start = 1'b0;
    logic        e_err = 1'b0;
    logic [3:0]  e_cnt = '0;

    param_frame_rx #(.HEADER(HDR), .TIMEOUT_CYC(TMO), .SYNC_STAGES(SYN)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .byte_in(byte_in), .byte_stb(byte_stb),
        .core_busy(core_busy), .a0(a0), .a1(a1), .start_calc(start_calc),
        .rx_busy(rx_busy), .frame_err(frame_err), .err_cnt(err_cnt)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [7:0] x;
        bit         acc;
        e_start = 1'b0;
        e_err   = 1'b0;
        if (!rst_n) begin
            for (int i = 0; i < SYN + 2; i++) stb_h[i] = 1'b0;
            m_mode = 0;
            m_fq.delete();
            m_idle = 0;
            e_a0   = '0;
            e_a1   = '0;
            e_cnt  = '0;
            return;
        end
        for (int i = SYN + 1; i > 0; i--) stb_h[i] = stb_h[i-1];
        stb_h[0] = byte_stb;
        // A pin rise sampled at edge k is accepted at edge k+SYN.
        acc = ena && stb_h[SYN] && !stb_h[SYN+1];
        if (!ena) begin
            m_mode = 0;
            m_fq.delete();
        end else if (m_mode == 0) begin
            if (acc && byte_in == HDR) begin
                m_mode = 1;
                m_fq.delete();
                m_idle = 0;
            end
        end else if (m_mode == 1) begin
            if (acc) begin
                m_fq.push_back(byte_in);
                m_idle = 0;
                if (m_fq.size() == 9) begin
                    x = 8'h00;
                    for (int i = 0; i < 8; i++) x ^= m_fq[i];
                    if (x == m_fq[8]) m_mode = 2;
                    else begin
                        e_err  = 1'b1;
                        m_mode = 0;
                    end
                end
            end else begin
                m_idle++;
                if (m_idle == TMO - 1) begin
                    e_err  = 1'b1;
                    m_mode = 0;
                end
            end
        end else begin
            if (acc) e_err = 1'b1;
            if (!core_busy) begin
                e_a0    = {m_fq[0], m_fq[1], m_fq[2], m_fq[3]};
                e_a1    = {m_fq[4], m_fq[5], m_fq[6], m_fq[7]};
                e_start = 1'b1;
                m_mode  = 0;
            end
        end
        if (e_err && e_cnt != 4'hF) e_cnt++;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && cmp_en) begin
            check("start_calc", 32'(start_calc), 32'(e_start));
            check("frame_err", 32'(frame_err), 32'(e_err));
            check("err_cnt", 32'(err_cnt), 32'(e_cnt));
            check("rx_busy", 32'(rx_busy), 32'(m_mode != 0));
            check("a0", a0, e_a0);
            check("a1", a1, e_a1);
            if (start_calc) start_seen++;
            if (frame_err) err_edge = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        byte_in = b;
        tick(1);
        byte_stb  = 1'b1;
        last_rise = cyc + 1;
        tick(4);
        byte_stb = 1'b0;
        tick(gap);
    endtask

    task automatic send_frame(input logic [31:0] w0, input logic [31:0] w1,
                              input bit force_chk, input logic [7:0] chk_val, input bit rnd);
        logic [7:0] fr[10];
        logic [63:0] pay;
        pay   = {w0, w1};
        fr[0] = HDR;
        fr[9] = 8'h00;
        for (int i = 0; i < 8; i++) begin
            fr[i+1] = pay[63-8*i -: 8];
            fr[9]   = fr[9] ^ fr[i+1];
        end
        if (force_chk) fr[9] = chk_val;
        for (int i = 0; i < 10; i++) begin
            if (rnd) begin
                if ($urandom_range(4) == 0) core_busy = ~core_busy;
                if ($urandom_range(40) == 0) begin
                    ena = 1'b0;
                    tick(1);
                    ena = 1'b1;
                end
                send_byte(fr[i], int'($urandom_range(1, 6)));
            end else begin
                send_byte(fr[i], 2);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        int          s0;
        logic [31:0] w0, w1;

        rst_n = 1'b0;
        tick(3);
        check("rst_a0", a0, 32'h0);
        check("rst_a1", a1, 32'h0);
        check("rst_start", 32'(start_calc), 32'h0);
        check("rst_busy", 32'(rx_busy), 32'h0);
        check("rst_err", 32'(frame_err), 32'h0);
        check("rst_cnt", 32'(err_cnt), 32'h0);
        rst_n  = 1'b1;
        ena    = 1'b1;
        cmp_en = 1'b1;
        tick(2);

        // Valid frame A5,00,01,00,00,FF,FF,80,00,81
        s0 = start_seen;
        send_frame(32'h00010000, 32'hFFFF8000, 1'b0, 8'h00, 1'b0);
        tick(3);
        check("valid_a0", a0, 32'h00010000);
        check("valid_a1", a1, 32'hFFFF8000);
        check("valid_cnt", 32'(err_cnt), 32'h0);
        check("valid_starts", 32'(start_seen - s0), 32'h1);

        // Same frame with CHK=0x80
        s0 = start_seen;
        send_frame(32'h00010000, 32'hFFFF8000, 1'b1, 8'h80, 1'b0);
        tick(3);
        check("badchk_cnt", 32'(err_cnt), 32'h1);
        check("badchk_a0", a0, 32'h00010000);
        check("badchk_busy", 32'(rx_busy), 32'h0);
        check("badchk_starts", 32'(start_seen - s0), 32'h0);

        // Busy hold with an overrun byte during the hold
        do_reset();
        s0 = start_seen;
        core_busy = 1'b1;
        send_frame(32'h00010000, 32'hFFFF8000, 1'b0, 8'h00, 1'b0);
        tick(10);
        check("hold_busy", 32'(rx_busy), 32'h1);
        send_byte(8'h33, 2);
        tick(2);
        check("hold_overrun_cnt", 32'(err_cnt), 32'h1);
        check("hold_no_start", 32'(start_seen - s0), 32'h0);
        tick(28);
        core_busy = 1'b0;
        tick(3);
        check("hold_a0", a0, 32'h00010000);
        check("hold_a1", a1, 32'hFFFF8000);
        check("hold_starts", 32'(start_seen - s0), 32'h1);
        check("hold_idle", 32'(rx_busy), 32'h0);

        // Garbage then a truncated frame that must time out
        do_reset();
        send_byte(8'h12, 2);
        send_byte(8'h34, 2);
        check("garbage_cnt", 32'(err_cnt), 32'h0);
        check("garbage_busy", 32'(rx_busy), 32'h0);
        send_byte(HDR, 2);
        send_byte(8'h00, 2);
        err_edge = -1;
        send_byte(8'h00, 0);
        tick(1100);
        check("tmo_latency", 32'(err_edge - last_rise), 32'(SYN + TMO - 1));
        check("tmo_cnt", 32'(err_cnt), 32'h1);
        check("tmo_idle", 32'(rx_busy), 32'h0);
        s0 = start_seen;
        send_frame(32'h00010000, 32'hFFFF8000, 1'b0, 8'h00, 1'b0);
        tick(3);
        check("tmo_next_a1", a1, 32'hFFFF8000);
        check("tmo_next_starts", 32'(start_seen - s0), 32'h1);

        // Reset in the middle of a frame
        send_frame(32'h12345678, 32'h9ABCDEF0, 1'b0, 8'h00, 1'b0);
        tick(3);
        check("pre_rst_a0", a0, 32'h12345678);
        send_byte(HDR, 2);
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 2);
        rst_n = 1'b0;
        #1;
        check("midrst_a0", a0, 32'h0);
        check("midrst_a1", a1, 32'h0);
        check("midrst_busy", 32'(rx_busy), 32'h0);
        check("midrst_cnt", 32'(err_cnt), 32'h0);
        tick(2);
        rst_n = 1'b1;
        s0 = start_seen;
        tick(20);
        check("midrst_no_start", 32'(start_seen - s0), 32'h0);

        // ena low for one cycle mid-frame
        send_frame(32'h12345678, 32'h9ABCDEF0, 1'b0, 8'h00, 1'b0);
        tick(3);
        s0 = start_seen;
        send_byte(HDR, 2);
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 2);
        ena = 1'b0;
        tick(1);
        ena = 1'b1;
        for (int i = 6; i <= 8; i++) send_byte(8'(i), 2);
        send_byte(8'h08, 2);
        tick(3);
        check("ena_cnt", 32'(err_cnt), 32'h0);
        check("ena_no_start", 32'(start_seen - s0), 32'h0);
        check("ena_a0", a0, 32'h12345678);
        check("ena_a1", a1, 32'h9ABCDEF0);
        check("ena_idle", 32'(rx_busy), 32'h0);

        // Randomised traffic: garbage, bad checksums, busy toggles, ena blips
        do_reset();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(3) == 0) send_byte(8'($urandom_range(255)), int'($urandom_range(1, 3)));
            w0 = $urandom;
            w1 = $urandom;
            send_frame(w0, w1, ($urandom_range(3) == 0), 8'($urandom_range(255)), 1'b1);
            tick(int'($urandom_range(0, 10)));
        end
        core_busy = 1'b0;
        tick(5);

        // Error counter saturation
        do_reset();
        s0 = start_seen;
        repeat (17) begin
            send_frame(32'h00010000, 32'hFFFF8000, 1'b1, 8'h80, 1'b0);
            tick(2);
        end
        check("sat_cnt", 32'(err_cnt), 32'hF);
        check("sat_no_start", 32'(start_seen - s0), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
